// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes, FSM encoding,
// ALU select codes and the control-word layout.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OpArithmetic    = 7'b0110011;
  localparam logic [6:0] OpArithmeticImm = 7'b0010011;
  localparam logic [6:0] OpLoad          = 7'b0000011;
  localparam logic [6:0] OpStore         = 7'b0100011;
  localparam logic [6:0] OpBranch        = 7'b1100011;
  localparam logic [6:0] OpJal           = 7'b1101111;
  localparam logic [6:0] OpJalr          = 7'b1100111;
  localparam logic [6:0] OpEcall         = 7'b1110011;

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StEx   = 4'd2,
    StMem  = 4'd3,
    StWb   = 4'd4,
    StJw   = 4'd5,
    StAdv  = 4'd6,
    StEc   = 4'd7,
    StHalt = 4'd8
  } state_e;

  localparam logic [1:0] SrcBRs2  = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBFour = 2'd2;

  localparam logic [1:0] AluAdd    = 2'd0;
  localparam logic [1:0] AluBranch = 2'd1;
  localparam logic [1:0] AluFunct  = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       is_ecall;
    logic       halted;
    logic       inst_done;
  } ctrl_t;

  // Opcodes that take the EX path out of ID.
  function automatic logic is_ex_opcode(logic [6:0] op);
    return (op == OpArithmetic) || (op == OpArithmeticImm) || (op == OpLoad) ||
           (op == OpStore) || (op == OpBranch) || (op == OpJal) || (op == OpJalr);
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational state+opcode to control-word mapper; every field not set for a state stays 0.
module mcu_output_decode
  import multicycle_control_unit_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       is_halted,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StIf: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
      end
      StId: ctrl.alu_src_b = SrcBImm;
      StEx: begin
        case (opcode)
          OpArithmetic: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = AluFunct;
          end
          OpArithmeticImm: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluFunct;
          end
          OpLoad, OpStore, OpJalr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
          end
          OpBranch: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = AluBranch;
            // Taken branch retires here using the target latched in ID.
            if (bcond) begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = 1'b1;
              ctrl.inst_done = 1'b1;
            end
          end
          OpJal: begin
            ctrl.alu_src_b = SrcBFour;
            ctrl.reg_write = 1'b1;
            ctrl.pc_to_reg = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b1;
            ctrl.inst_done = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        ctrl.i_or_d = 1'b1;
        if (opcode == OpStore) begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src_b = SrcBFour;
          ctrl.pc_write  = 1'b1;
          ctrl.inst_done = 1'b1;
        end else begin
          ctrl.mem_read = 1'b1;
        end
      end
      StWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (opcode == OpLoad);
        ctrl.alu_src_b  = SrcBFour;
        ctrl.pc_write   = 1'b1;
        ctrl.inst_done  = 1'b1;
      end
      StJw: begin
        ctrl.alu_src_b = SrcBFour;
        ctrl.reg_write = 1'b1;
        ctrl.pc_to_reg = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b1;
        ctrl.inst_done = 1'b1;
      end
      StAdv: begin
        ctrl.alu_src_b = SrcBFour;
        ctrl.pc_write  = 1'b1;
        ctrl.inst_done = 1'b1;
      end
      StEc: begin
        ctrl.is_ecall = 1'b1;
        if (!is_halted) begin
          ctrl.alu_src_b = SrcBFour;
          ctrl.pc_write  = 1'b1;
          ctrl.inst_done = 1'b1;
        end
      end
      StHalt: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: state register, next-state logic and gated control outputs.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       is_halted,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       is_ecall,
  output logic       halted,
  output logic       inst_done
);
  import multicycle_control_unit_pkg::*;

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (opcode == OpEcall) begin
          state_d = StEc;
        end else if (is_ex_opcode(opcode)) begin
          state_d = StEx;
        end else begin
          state_d = StAdv;
        end
      end
      StEx: begin
        case (opcode)
          OpArithmetic, OpArithmeticImm: state_d = StWb;
          OpLoad, OpStore:               state_d = StMem;
          OpBranch:                      state_d = bcond ? StIf : StAdv;
          OpJal:                         state_d = StIf;
          OpJalr:                        state_d = StJw;
          default:                       state_d = StAdv;
        endcase
      end
      StMem:             state_d = (opcode == OpStore) ? StIf : StWb;
      StWb, StJw, StAdv: state_d = StIf;
      StEc:              state_d = is_halted ? StHalt : StIf;
      StHalt:            state_d = StHalt;
      default:           state_d = StIf;
    endcase
  end

  mcu_output_decode u_output_decode (
    .state     (state_q),
    .opcode    (opcode),
    .bcond     (bcond),
    .is_halted (is_halted),
    .ctrl      (ctrl)
  );

  // State already reads IF during reset, so strobes are masked until it is released.
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign mem_read   = ctrl.mem_read  & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign inst_done  = ctrl.inst_done & ~reset;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_to_reg  = ctrl.pc_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign is_ecall   = ctrl.is_ecall;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control-word checks against
// hand-derived vectors for every instruction class, halt and reset abort.
module tb_multicycle_control_unit;

  // Vector layout: pw irw iod mr mw m2r rw p2r sa sb[1:0] op[1:0] ps ec h done
  localparam logic [16:0] ExpZero  = 17'b0_0_0_0_0_0_0_0_0_00_00_0_0_0_0;
  localparam logic [16:0] ExpIf    = 17'b0_1_0_1_0_0_0_0_0_00_00_0_0_0_0;
  localparam logic [16:0] ExpId    = 17'b0_0_0_0_0_0_0_0_0_01_00_0_0_0_0;
  localparam logic [16:0] ExpExR   = 17'b0_0_0_0_0_0_0_0_1_00_10_0_0_0_0;
  localparam logic [16:0] ExpExI   = 17'b0_0_0_0_0_0_0_0_1_01_10_0_0_0_0;
  localparam logic [16:0] ExpExLs  = 17'b0_0_0_0_0_0_0_0_1_01_00_0_0_0_0;
  localparam logic [16:0] ExpBrT   = 17'b1_0_0_0_0_0_0_0_1_00_01_1_0_0_1;
  localparam logic [16:0] ExpBrN   = 17'b0_0_0_0_0_0_0_0_1_00_01_0_0_0_0;
  localparam logic [16:0] ExpJmp   = 17'b1_0_0_0_0_0_1_1_0_10_00_1_0_0_1;
  localparam logic [16:0] ExpMemLd = 17'b0_0_1_1_0_0_0_0_0_00_00_0_0_0_0;
  localparam logic [16:0] ExpMemSt = 17'b1_0_1_0_1_0_0_0_0_10_00_0_0_0_1;
  localparam logic [16:0] ExpWbR   = 17'b1_0_0_0_0_0_1_0_0_10_00_0_0_0_1;
  localparam logic [16:0] ExpWbLd  = 17'b1_0_0_0_0_1_1_0_0_10_00_0_0_0_1;
  localparam logic [16:0] ExpAdv   = 17'b1_0_0_0_0_0_0_0_0_10_00_0_0_0_1;
  localparam logic [16:0] ExpEcNh  = 17'b1_0_0_0_0_0_0_0_0_10_00_0_1_0_1;
  localparam logic [16:0] ExpEcH   = 17'b0_0_0_0_0_0_0_0_0_00_00_0_1_0_0;
  localparam logic [16:0] ExpHalt  = 17'b0_0_0_0_0_0_0_0_0_00_00_0_0_1_0;

  logic       clk, reset, bcond, is_halted;
  logic [6:0] opcode;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write;
  logic       pc_to_reg, alu_src_a, pc_source, is_ecall, halted, inst_done;
  logic [1:0] alu_src_b, alu_op;
  logic [16:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .bcond      (bcond),
    .is_halted  (is_halted),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .pc_to_reg  (pc_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .is_ecall   (is_ecall),
    .halted     (halted),
    .inst_done  (inst_done)
  );

  assign outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
                 pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, is_ecall, halted,
                 inst_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; checks the current cycle then moves to the next one.
  task automatic step(input string tag, input logic [16:0] exp);
    #1;
    check(tag, outs, exp);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 7'h00;
    bcond     = 1'b0;
    is_halted = 1'b0;
    @(negedge clk);
    #1;
    check("reset_outputs", outs, ExpZero);
    reset = 1'b0;

    // ADD, with is_halted noise that must be ignored outside EC
    opcode = 7'b0110011;
    is_halted = 1'b1;
    step("add_if", ExpIf);
    step("add_id", ExpId);
    step("add_ex", ExpExR);
    step("add_wb", ExpWbR);
    is_halted = 1'b0;

    opcode = 7'b0010011;
    step("addi_if", ExpIf);
    step("addi_id", ExpId);
    step("addi_ex", ExpExI);
    step("addi_wb", ExpWbR);

    opcode = 7'b0000011;
    step("lw_if", ExpIf);
    step("lw_id", ExpId);
    step("lw_ex", ExpExLs);
    step("lw_mem", ExpMemLd);
    step("lw_wb", ExpWbLd);

    opcode = 7'b0100011;
    step("sw_if", ExpIf);
    step("sw_id", ExpId);
    step("sw_ex", ExpExLs);
    step("sw_mem", ExpMemSt);

    opcode = 7'b1100011;
    bcond = 1'b1;
    step("beqt_if", ExpIf);
    step("beqt_id", ExpId);
    step("beqt_ex", ExpBrT);

    // bcond high outside EX must not make the branch taken
    step("beqn_if", ExpIf);
    step("beqn_id", ExpId);
    bcond = 1'b0;
    step("beqn_ex", ExpBrN);
    bcond = 1'b1;
    step("beqn_adv", ExpAdv);
    bcond = 1'b0;

    opcode = 7'b1101111;
    step("jal_if", ExpIf);
    step("jal_id", ExpId);
    step("jal_ex", ExpJmp);

    opcode = 7'b1100111;
    step("jalr_if", ExpIf);
    step("jalr_id", ExpId);
    step("jalr_ex", ExpExLs);
    step("jalr_jw", ExpJmp);

    opcode = 7'h00;
    step("unk_if", ExpIf);
    step("unk_id", ExpId);
    step("unk_adv", ExpAdv);

    opcode = 7'b1110011;
    step("ecall_if", ExpIf);
    step("ecall_id", ExpId);
    step("ecall_ec", ExpEcNh);

    // Reset during MEM of a store
    opcode = 7'b0100011;
    step("swr_if", ExpIf);
    step("swr_id", ExpId);
    step("swr_ex", ExpExLs);
    #1;
    check("swr_mem", outs, ExpMemSt);
    reset = 1'b1;
    #1;
    check("swr_reset_drop", outs, ExpZero);
    @(negedge clk);
    #1;
    check("swr_reset_hold", outs, ExpZero);
    reset = 1'b0;
    opcode = 7'h00;
    step("zero_if", ExpIf);
    step("zero_id", ExpId);
    step("zero_adv", ExpAdv);

    // Halting ECALL, then reset out of HALT
    opcode = 7'b1110011;
    is_halted = 1'b1;
    step("halt_if", ExpIf);
    step("halt_id", ExpId);
    step("halt_ec", ExpEcH);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) opcode = 7'b0110011;
      step("halt_hold", ExpHalt);
    end
    reset = 1'b1;
    #1;
    check("halt_reset", outs, ExpZero);
    @(negedge clk);
    reset = 1'b0;
    is_halted = 1'b0;
    opcode = 7'b0010011;
    step("post_if", ExpIf);
    step("post_id", ExpId);
    step("post_ex", ExpExI);
    step("post_wb", ExpWbR);
    step("post_next_if", ExpIf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have these ports, clock and reset first:
  clk  in  1  sole clock, all state changes on rising edge
  reset  in  1  asynchronous, active-high; clears FSM immediately
  opcode  in  7  IR[6:0] from the datapath, stable from ID onward
  bcond  in  1  ALU branch-compare result, valid in EX for BRANCH
  is_halted  in  1  datapath flag for an ECALL with x17==10
  pc_write  out  1  PC load enable
  ir_write  out  1  IR load enable
  i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
  mem_read  out  1  memory read strobe
  mem_write  out  1  memory write strobe
  mem_to_reg  out  1  register write-data select: 1=MDR
  reg_write  out  1  register file write enable
  pc_to_reg  out  1  register write-data select: ALU result (PC+4)
  alu_src_a  out  1  ALU A select: 0=PC, 1=rs1
  alu_src_b  out  2  ALU B select: 0=rs2, 1=imm, 2=constant 4
  alu_op  out  2  0=add, 1=branch compare, 2=funct-decoded
  pc_source  out  1  PC next value: 0=ALU result, 1=ALUOut
  is_ecall  out  1  high in EC state
  halted  out  1  high in HALT state
  inst_done  out  1  one-cycle pulse on the final cycle of each retired instruction
REQ-002 Opcode constants (ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL) SHALL come from the shared opcode definitions.

Function
REQ-003 The FSM SHALL have states IF, ID, EX, MEM, WB, JW, ADV, EC, HALT. Outputs SHALL be Moore, and every unlisted output SHALL be 0.
REQ-004 IF: mem_read=1, i_or_d=0, ir_write=1; next state ID.
REQ-005 ID: ALU computes PC+imm (src_a=0, src_b=1, op=0). Next state: ECALL->EC; ARITHMETIC/ARITHMETIC_IMM/LOAD/STORE/BRANCH/JAL/JALR->EX; any other opcode, including 7'h00->ADV.
REQ-006 EX for ARITHMETIC: src_a=1, src_b=0, op=2; next state WB.
REQ-007 EX for ARITHMETIC_IMM: src_a=1, src_b=1, op=2; next state WB.
REQ-008 EX for LOAD/STORE: src_a=1, src_b=1, op=0; next state MEM.
REQ-009 EX for BRANCH: src_a=1, src_b=0, op=1. If bcond=1: pc_write=1, pc_source=1, inst_done=1, next state IF. Otherwise next state ADV.
REQ-010 EX for JAL: src_a=0, src_b=2, op=0, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=1, inst_done=1; next state IF.
REQ-011 EX for JALR: src_a=1, src_b=1, op=0; next state JW.
REQ-012 JW: src_a=0, src_b=2, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=1, inst_done=1; next state IF.
REQ-013 MEM for LOAD: mem_read=1, i_or_d=1; next state WB.
REQ-014 MEM for STORE: mem_write=1, i_or_d=1, src_a=0, src_b=2, pc_write=1, pc_source=0, inst_done=1; next state IF.
REQ-015 WB: reg_write=1, mem_to_reg=(opcode==LOAD), src_a=0, src_b=2, op=0, pc_write=1, pc_source=0, inst_done=1; next state IF.
REQ-016 ADV: src_a=0, src_b=2, pc_write=1, pc_source=0, inst_done=1; next state IF.
REQ-017 EC: is_ecall=1. If is_halted=1: pc_write=0, next state HALT. Otherwise behaves as ADV (PC+4, inst_done=1), next state IF.
REQ-018 HALT: halted=1; all write enables and strobes SHALL be 0; state persists until reset.
REQ-019 Instruction latency SHALL be:
  3 cycles: taken branch, JAL, unknown opcode
  4 cycles: R/I arithmetic, store, not-taken branch, JALR
  5 cycles: load
  3 cycles: non-halting ECALL
REQ-020 opcode and bcond SHALL be sampled only in the states listed above; changes elsewhere SHALL have no effect.

Reset
REQ-021 reset=1 SHALL force state IF asynchronously. While reset is high, pc_write, ir_write, mem_read, mem_write, reg_write and inst_done SHALL be 0.
REQ-022 Reset asserted mid-instruction, including in HALT, SHALL abort that instruction with no further writes. The first rising edge after deassertion SHALL execute IF.

Structure
REQ-023 The state encoding (4-bit) and the alu_src_b/alu_op codes SHALL be defined in a shared package alongside the opcode constants.
REQ-024 The design SHALL be split into a state register plus next-state logic and one sub-module, mcu_output_decode, a combinational state+opcode -> control-word mapper.

Verification
REQ-025 ADD x3,x1,x2 (opcode 0110011) after reset: states IF,ID,EX,WB; reg_write=1 and pc_write=1 in cycle 4 only; inst_done pulses once.
REQ-026 LW (0000011): 5 cycles; mem_read=1 with i_or_d=1 in cycle 4; reg_write=1 with mem_to_reg=1 in cycle 5.
REQ-027 BEQ (1100011): with bcond=1, pc_write=1 and pc_source=1 in cycle 3, then IF. With bcond=0, ADV in cycle 4 with pc_source=0.
REQ-028 JALR (1100111): cycle 4 (JW) shows reg_write=1, pc_to_reg=1, pc_source=1; JAL completes the same in cycle 3.
REQ-029 ECALL (1110011): with is_halted=1, EC then HALT; halted stays 1 for 20 cycles with no writes. Asserting reset then returns to IF.
REQ-030 Reset pulsed during MEM of a STORE: mem_write drops immediately, the next cycle is IF, and opcode 7'h00 retires via ADV in 3 cycles.
